// File: rtl/dm_abstract_ctl_pkg.sv
// Shared types, cmderr codes, command types and command field extractors
// for the debug module abstract-command sequencer.
package dm_abstract_ctl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
    localparam logic [2:0] CMDERR_BUS        = 3'd5;
    localparam logic [2:0] CMDERR_OTHER      = 3'd7;

    localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'd0;
    localparam logic [7:0] CMDTYPE_ACCESS_MEM = 8'd2;

    // CSRs occupy 0x0000-0x0FFF, GPRs 0x1000-0x101F; everything above is rejected.
    localparam logic [15:0] REGNO_LAST = 16'h101F;

    function automatic logic [7:0] cmd_type(input logic [31:0] cmd);
        return cmd[31:24];
    endfunction

    function automatic logic cmd_aamvirtual(input logic [31:0] cmd);
        return cmd[23];
    endfunction

    // aarsize and aamsize share the same bit positions.
    function automatic logic [2:0] cmd_aarsize(input logic [31:0] cmd);
        return cmd[22:20];
    endfunction

    function automatic logic [2:0] cmd_aamsize(input logic [31:0] cmd);
        return cmd[22:20];
    endfunction

    function automatic logic cmd_postincrement(input logic [31:0] cmd);
        return cmd[19];
    endfunction

    function automatic logic cmd_postexec(input logic [31:0] cmd);
        return cmd[18];
    endfunction

    function automatic logic cmd_transfer(input logic [31:0] cmd);
        return cmd[17];
    endfunction

    function automatic logic [15:0] cmd_regno(input logic [31:0] cmd);
        return cmd[15:0];
    endfunction

endpackage

// File: rtl/dm_abstract_ctl_if.sv
// Hart-facing debug interface between the debug module and one hart.
interface dm_abstract_ctl_if;
    // Handshake: the DM raises exec with a stable command and holds both until
    // the hart returns done (error qualified by done); write may pulse any
    // cycle while exec is high to deliver hart_wdata into data0.
    logic        halt_req;
    logic        resume_req;
    logic [31:0] command;
    logic        exec;
    logic        halted;
    logic        done;
    logic        write;
    logic        error;
    logic [31:0] hart_wdata;

    modport master (
        output halt_req, resume_req, command, exec,
        input  halted, done, write, error, hart_wdata
    );

    modport slave (
        input  halt_req, resume_req, command, exec,
        output halted, done, write, error, hart_wdata
    );
endinterface

// File: rtl/dm_ac_decode.sv
// Classifies a written abstract command: supported, memory access,
// register access without transfer, and the post-increment step.
module dm_ac_decode
    import dm_abstract_ctl_pkg::*;
(
    input  logic [31:0] cmd,
    output logic        supported,
    output logic        is_memory,
    output logic        no_transfer,
    output logic [31:0] incr_amount
);

    logic is_register;
    logic reg_ok;
    logic mem_ok;

    assign is_register = (cmd_type(cmd) == CMDTYPE_ACCESS_REG);
    assign is_memory   = (cmd_type(cmd) == CMDTYPE_ACCESS_MEM);

    assign reg_ok = (cmd_aarsize(cmd) == 3'd2) && !cmd_postincrement(cmd) &&
                    !cmd_postexec(cmd) && (cmd_regno(cmd) <= REGNO_LAST);
    assign mem_ok = !cmd_aamvirtual(cmd) && (cmd_aamsize(cmd) <= 3'd2);

    assign supported   = (is_register && reg_ok) || (is_memory && mem_ok);
    assign no_transfer = is_register && !cmd_transfer(cmd);
    assign incr_amount = (is_memory && cmd_postincrement(cmd)) ?
                         (32'd1 << cmd_aamsize(cmd)) : 32'd0;

endmodule

// File: rtl/dm_abstract_ctl.sv
// Debug module abstract-command and run-control sequencer: owns busy/cmderr,
// data0/data1 and the halt/resume requests toward the hart.
module dm_abstract_ctl
    import dm_abstract_ctl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dmactive,
    input  logic               haltreq_i,
    input  logic               resumereq_i,
    input  logic               cmd_wr,
    input  logic [31:0]        cmd_wdata,
    input  logic               cmderr_w1c,
    input  logic [2:0]         cmderr_wdata,
    input  logic               data0_wr,
    input  logic               data1_wr,
    input  logic [31:0]        dmi_wdata,
    dm_abstract_ctl_if.master  dbg,
    output logic               busy,
    output logic [2:0]         cmderr,
    output logic               allhalted,
    output logic               allresumeack,
    output logic [31:0]        data0,
    output logic [31:0]        data1,
    output state_t             dbg_state
);

    localparam int unsigned      CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          clr;
    logic          dec_supported, dec_is_memory, dec_no_transfer;
    logic [31:0]   dec_incr;
    logic          start_exec, exec_end, idle_err_en;
    logic [2:0]    idle_err_code, cmderr_nxt;
    logic          exec_c;
    logic [CW-1:0] cnt;
    logic          is_mem_q;
    logic [31:0]   incr_q, command_q;
    logic          resume_q;
    logic          timed_out;

    // dmactive low behaves exactly like rst_n low for every register.
    assign clr = !rst_n || !dmactive;

    dm_ac_decode u_decode (
        .cmd         (cmd_wdata),
        .supported   (dec_supported),
        .is_memory   (dec_is_memory),
        .no_transfer (dec_no_transfer),
        .incr_amount (dec_incr)
    );

    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    assign timed_out = (cnt == CNT_LAST) && !dbg.done;

    always_comb begin
        state_nxt     = state;
        start_exec    = 1'b0;
        exec_end      = 1'b0;
        idle_err_en   = 1'b0;
        idle_err_code = CMDERR_NONE;
        case (state)
            ST_IDLE: begin
                if (cmd_wr && (cmderr == CMDERR_NONE)) begin
                    if (!dec_supported) begin
                        idle_err_en   = 1'b1;
                        idle_err_code = CMDERR_NOTSUP;
                    end else if (!dbg.halted) begin
                        idle_err_en   = 1'b1;
                        idle_err_code = CMDERR_HALTRESUME;
                    end else if (!dec_no_transfer) begin
                        start_exec = 1'b1;
                        state_nxt  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (dbg.done || timed_out) begin
                    exec_end  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        exec_c = 1'b0;
        case (state)
            ST_EXEC: exec_c = 1'b1;
            default: exec_c = 1'b0;
        endcase
    end

    assign busy      = exec_c;
    assign dbg.exec  = exec_c;
    assign dbg_state = state;

    // Clears are applied first so any error set in the same cycle overrides them.
    always_comb begin
        cmderr_nxt = cmderr;
        if (cmderr_w1c)
            cmderr_nxt = cmderr & ~cmderr_wdata;
        if (exec_c && (cmd_wr || data0_wr || data1_wr) && (cmderr == CMDERR_NONE))
            cmderr_nxt = CMDERR_BUSY;
        if (idle_err_en)
            cmderr_nxt = idle_err_code;
        if (exec_c && dbg.done && dbg.error)
            cmderr_nxt = is_mem_q ? CMDERR_BUS : CMDERR_EXCEPTION;
        else if (exec_c && timed_out)
            cmderr_nxt = CMDERR_OTHER;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cmderr    <= CMDERR_NONE;
            command_q <= '0;
            is_mem_q  <= 1'b0;
            incr_q    <= '0;
            cnt       <= '0;
            data0     <= '0;
            data1     <= '0;
        end else begin
            cmderr <= cmderr_nxt;
            if (start_exec) begin
                command_q <= cmd_wdata;
                is_mem_q  <= dec_is_memory;
                incr_q    <= dec_incr;
                cnt       <= '0;
            end else if (exec_c && !exec_end) begin
                cnt <= cnt + CW'(1);
            end
            if (exec_c) begin
                if (dbg.write) data0 <= dbg.hart_wdata;
                if (dbg.done && !dbg.error) data1 <= data1 + incr_q;
            end else begin
                if (data0_wr) data0 <= dmi_wdata;
                if (data1_wr) data1 <= dmi_wdata;
            end
        end
    end

    // A resume is acknowledged on the first cycle the hart reports running.
    always_ff @(posedge clk) begin
        if (clr) begin
            resume_q     <= 1'b0;
            allresumeack <= 1'b0;
        end else if (resume_q && !dbg.halted) begin
            resume_q     <= 1'b0;
            allresumeack <= 1'b1;
        end else if (resumereq_i && !haltreq_i && !exec_c && dbg.halted) begin
            resume_q     <= 1'b1;
            allresumeack <= 1'b0;
        end
    end

    assign dbg.resume_req = resume_q;
    assign dbg.command    = command_q;
    assign dbg.halt_req   = haltreq_i && dmactive;
    assign allhalted      = dbg.halted;

endmodule

// File: tb/tb_dm_abstract_ctl.sv
// Bench for dm_abstract_ctl: directed scenarios followed by randomized
// traffic, each cycle compared against a behavioural model.
module tb_dm_abstract_ctl;
    import dm_abstract_ctl_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n, dmactive, haltreq_i, resumereq_i;
    logic        cmd_wr, cmderr_w1c, data0_wr, data1_wr;
    logic [31:0] cmd_wdata, dmi_wdata;
    logic [2:0]  cmderr_wdata;
    logic        busy, allhalted, allresumeack;
    logic [2:0]  cmderr;
    logic [31:0] data0, data1;
    state_t      dbg_state;

    dm_abstract_ctl_if dbg_if ();

    dm_abstract_ctl #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmactive     (dmactive),
        .haltreq_i    (haltreq_i),
        .resumereq_i  (resumereq_i),
        .cmd_wr       (cmd_wr),
        .cmd_wdata    (cmd_wdata),
        .cmderr_w1c   (cmderr_w1c),
        .cmderr_wdata (cmderr_wdata),
        .data0_wr     (data0_wr),
        .data1_wr     (data1_wr),
        .dmi_wdata    (dmi_wdata),
        .dbg          (dbg_if),
        .busy         (busy),
        .cmderr       (cmderr),
        .allhalted    (allhalted),
        .allresumeack (allresumeack),
        .data0        (data0),
        .data1        (data1),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h required=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_busy, m_mem, m_resume, m_ack;
    logic [31:0] m_cmd, m_data0, m_data1, m_incr;
    logic [2:0]  m_cmderr;
    int          m_age;

    function automatic bit m_supported(input logic [31:0] c);
        int unsigned ty, sz;
        ty = c >> 24;
        sz = (c >> 20) & 7;
        if (ty == 0) return (sz == 2) && (((c >> 18) & 3) == 0) && ((c & 32'hFFFF) < 32'h1020);
        if (ty == 2) return (((c >> 23) & 1) == 0) && (sz <= 2);
        return 1'b0;
    endfunction

    function automatic bit m_needs_exec(input logic [31:0] c);
        return ((c >> 24) == 2) || (((c >> 17) & 1) == 1);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_mem = 0; m_resume = 0; m_ack = 0;
        m_cmd = 0; m_data0 = 0; m_data1 = 0; m_incr = 0; m_cmderr = 0; m_age = 0;
    endtask

    // Applies one clock edge, using the inputs that were present at that edge.
    task automatic model_edge();
        bit         was_busy;
        logic [2:0] err;
        if (!rst_n || !dmactive) begin
            model_reset();
            return;
        end
        was_busy = m_busy;
        err      = m_cmderr;
        if (cmderr_w1c) err = err & ~cmderr_wdata;
        if (was_busy) begin
            if ((cmd_wr || data0_wr || data1_wr) && m_cmderr == 0) err = 3'd1;
            if (dbg_if.write) m_data0 = dbg_if.hart_wdata;
            if (dbg_if.done) begin
                if (dbg_if.error) err = m_mem ? 3'd5 : 3'd3;
                else m_data1 = m_data1 + m_incr;
                m_busy = 0;
                exp_q.push_back(m_data0);
            end else if (m_age == TIMEOUT - 1) begin
                err    = 3'd7;
                m_busy = 0;
                exp_q.push_back(m_data0);
            end else begin
                m_age++;
            end
        end else begin
            if (data0_wr) m_data0 = dmi_wdata;
            if (data1_wr) m_data1 = dmi_wdata;
            if (cmd_wr && m_cmderr == 0) begin
                if (!m_supported(cmd_wdata)) err = 3'd2;
                else if (!dbg_if.halted) err = 3'd4;
                else if (m_needs_exec(cmd_wdata)) begin
                    m_busy = 1;
                    m_cmd  = cmd_wdata;
                    m_mem  = (cmd_wdata >> 24) == 2;
                    m_incr = (m_mem && ((cmd_wdata >> 19) & 1)) ? (32'd1 << ((cmd_wdata >> 20) & 7)) : 32'd0;
                    m_age  = 0;
                end
            end
        end
        m_cmderr = err;
        if (m_resume && !dbg_if.halted) begin
            m_resume = 0;
            m_ack    = 1;
        end else if (resumereq_i && !haltreq_i && !was_busy && dbg_if.halted) begin
            m_resume = 1;
            m_ack    = 0;
        end
    endtask

    task automatic compare_all();
        logic [31:0] e;
        check_eq("busy",         busy,              m_busy);
        check_eq("exec",         dbg_if.exec,       m_busy);
        check_eq("command",      dbg_if.command,    m_cmd);
        check_eq("cmderr",       cmderr,            m_cmderr);
        check_eq("data0",        data0,             m_data0);
        check_eq("data1",        data1,             m_data1);
        check_eq("resume_req",   dbg_if.resume_req, m_resume);
        check_eq("allresumeack", allresumeack,      m_ack);
        check_eq("halt_req",     dbg_if.halt_req,   haltreq_i && dmactive);
        check_eq("allhalted",    allhalted,         dbg_if.halted);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("sb_cmpl_data0", data0, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_strobes();
        resumereq_i = 0; cmd_wr = 0; cmderr_w1c = 0; data0_wr = 0; data1_wr = 0;
        dbg_if.done = 0; dbg_if.write = 0; dbg_if.error = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
        clear_strobes();
    endtask

    task automatic write_cmd(input logic [31:0] c);
        cmd_wr = 1; cmd_wdata = c;
        step();
    endtask

    task automatic clear_err();
        cmderr_w1c = 1; cmderr_wdata = 3'b111;
        step();
    endtask

    function automatic logic [31:0] gen_cmd();
        logic [31:0] c;
        case ($urandom_range(0, 5))
            0: c = 32'h0022_0000 | ($urandom_range(0, 1) ? (32'h1000 + $urandom_range(0, 31)) : $urandom_range(0, 16'h1040));
            1: c = 32'h0020_0000 | $urandom_range(0, 16'h101F);
            2: c = 32'h0200_0000 | ($urandom_range(0, 3) << 20) | ($urandom_range(0, 1) << 19) |
                   ($urandom_range(0, 1) << 16) | (($urandom_range(0, 7) == 0) << 23);
            3: c = 32'h0002_1000 | ($urandom_range(0, 7) << 20) | ($urandom_range(0, 3) << 18);
            4: c = ($urandom_range(0, 1) ? 32'h0100_0000 : 32'h0322_1001);
            default: c = $urandom;
        endcase
        return c;
    endfunction

    // ---------------- stimulus ----------------
    int cnt;

    initial begin
        rst_n = 0; dmactive = 1; haltreq_i = 0; cmd_wdata = 0; dmi_wdata = 0; cmderr_wdata = 0;
        dbg_if.halted = 1; dbg_if.hart_wdata = 0;
        clear_strobes();
        model_reset();
        step();
        step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmderr", cmderr, 0);
        rst_n = 1;
        step();

        // Register read of x1 returning 0xDEADBEEF.
        write_cmd(32'h0022_1001);
        check_eq("read_exec", dbg_if.exec, 1);
        check_eq("read_command", dbg_if.command, 32'h0022_1001);
        dbg_if.write = 1; dbg_if.done = 1; dbg_if.hart_wdata = 32'hDEAD_BEEF;
        step();
        check_eq("read_data0", data0, 32'hDEAD_BEEF);
        check_eq("read_busy", busy, 0);
        check_eq("read_cmderr", cmderr, 0);

        // Memory access with post-increment wraps data1.
        data1_wr = 1; dmi_wdata = 32'hFFFF_FFFC;
        step();
        write_cmd(32'h0228_0000);
        dbg_if.done = 1;
        step();
        check_eq("postinc_wrap", data1, 32'h0000_0000);

        // Writes while busy, then a command blocked by a sticky cmderr.
        write_cmd(32'h0022_1002);
        write_cmd(32'h0022_1003);
        check_eq("busy_wr_err", cmderr, 1);
        check_eq("busy_wr_cmd", dbg_if.command, 32'h0022_1002);
        dbg_if.done = 1;
        step();
        write_cmd(32'h0022_1001);
        check_eq("sticky_no_exec", dbg_if.exec, 0);
        clear_err();
        check_eq("w1c_clear", cmderr, 0);

        // Error classes.
        dbg_if.halted = 0;
        write_cmd(32'h0022_1001);
        check_eq("not_halted", cmderr, 4);
        clear_err();
        dbg_if.halted = 1;
        write_cmd(32'h0032_1001);
        check_eq("bad_aarsize", cmderr, 2);
        clear_err();
        write_cmd(32'h0220_0000);
        dbg_if.done = 1; dbg_if.error = 1;
        step();
        check_eq("mem_error", cmderr, 5);
        clear_err();

        // Timeout with done withheld.
        write_cmd(32'h0022_1005);
        cnt = dbg_if.exec ? 1 : 0;
        for (int i = 0; i < 40 && dbg_if.exec; i++) begin
            step();
            if (dbg_if.exec) cnt++;
        end
        check_eq("timeout_cycles", cnt, TIMEOUT);
        check_eq("timeout_cmderr", cmderr, 7);
        clear_err();

        // Run control.
        haltreq_i = 1; dbg_if.halted = 0;
        step();
        check_eq("halt_req_on", dbg_if.halt_req, 1);
        check_eq("allhalted_0", allhalted, 0);
        dbg_if.halted = 1;
        resumereq_i = 1;
        step();
        check_eq("resume_blocked", dbg_if.resume_req, 0);
        haltreq_i = 0; resumereq_i = 1;
        step();
        check_eq("resume_set", dbg_if.resume_req, 1);
        check_eq("resume_ack0", allresumeack, 0);
        step();
        check_eq("resume_hold", dbg_if.resume_req, 1);
        dbg_if.halted = 0;
        step();
        check_eq("resume_clr", dbg_if.resume_req, 0);
        check_eq("resume_ack1", allresumeack, 1);
        dbg_if.halted = 1;
        step();

        // dmactive dropped mid-EXEC, late done ignored.
        write_cmd(32'h0022_1001);
        dmactive = 0;
        step();
        check_eq("dmact_exec", dbg_if.exec, 0);
        check_eq("dmact_data0", data0, 0);
        check_eq("dmact_ack", allresumeack, 0);
        dmactive = 1; dbg_if.done = 1; dbg_if.write = 1; dbg_if.hart_wdata = 32'h1234_5678;
        step();
        check_eq("late_done_data0", data0, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst_n         = ($urandom_range(0, 499) != 0);
            dmactive      = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0) haltreq_i = ~haltreq_i;
            if ($urandom_range(0, 19) == 0) dbg_if.halted = ~dbg_if.halted;
            resumereq_i   = ($urandom_range(0, 9) == 0);
            cmd_wr        = ($urandom_range(0, 5) == 0);
            cmd_wdata     = gen_cmd();
            cmderr_w1c    = ($urandom_range(0, 11) == 0);
            cmderr_wdata  = $urandom_range(0, 7);
            data0_wr      = ($urandom_range(0, 9) == 0);
            data1_wr      = ($urandom_range(0, 9) == 0);
            dmi_wdata     = $urandom;
            dbg_if.done   = ($urandom_range(0, 3) == 0);
            dbg_if.write  = ($urandom_range(0, 2) == 0);
            dbg_if.error  = ($urandom_range(0, 3) == 0);
            dbg_if.hart_wdata = $urandom;
            step();
        end

        check_eq("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
